// File: rtl/pixel_stream_feeder.sv
// Line-credit pixel feeder: forwards one upstream pixel per cycle into the
// window controller, stalling when the controller has no free line buffer.
// Ports: i_clk/i_rst_n (async active-low), i_start frame start,
//   i_s_data/i_s_valid/o_s_ready upstream stream, o_pixel_data/_valid out,
//   i_intr line-consumed interrupt, o_busy, o_line_count, o_frame_done.
module pixel_stream_feeder #(
    parameter int IMG_WIDTH     = 512,
    parameter int IMG_HEIGHT    = 512,
    parameter int PRELOAD_LINES = 4
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_start,
    input  logic [7:0]                        i_s_data,
    input  logic                              i_s_valid,
    output logic                              o_s_ready,
    output logic [7:0]                        o_pixel_data,
    output logic                              o_pixel_data_valid,
    input  logic                              i_intr,
    output logic                              o_busy,
    output logic [$clog2(IMG_HEIGHT+1)-1:0]   o_line_count,
    output logic                              o_frame_done
);

    localparam int COLW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int LCW  = $clog2(IMG_HEIGHT + 1);
    localparam int CRW  = $clog2(PRELOAD_LINES + 1);

    localparam logic [COLW-1:0] COL_LAST  = COLW'(IMG_WIDTH - 1);
    localparam logic [LCW-1:0]  LINE_LAST = LCW'(IMG_HEIGHT - 1);
    localparam logic [CRW-1:0]  CR_MAX    = CRW'(PRELOAD_LINES);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_CREDIT,
        DONE
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [COLW-1:0] col;
    logic [CRW-1:0]  credits;
    logic [CRW-1:0]  credits_nx;
    logic            intr_d;
    logic            transfer;
    logic            line_end;
    logic            credit_event;
    logic            start_ok;

    assign start_ok = (state == IDLE) && i_start;
    assign transfer = (state == SEND) && i_s_valid;
    assign line_end = transfer && (col == COL_LAST);

    // Interrupt edges only count while a frame is streaming.
    assign credit_event = i_intr && !intr_d &&
                          ((state == SEND) || (state == WAIT_CREDIT));

    // A line end always has at least one credit to spend, so the
    // decrement cannot underflow and the sum cannot pass the ceiling.
    always_comb begin
        credits_nx = credits;
        if (start_ok) begin
            credits_nx = CR_MAX;
        end else if (line_end) begin
            credits_nx = credits - CRW'(1) + CRW'(credit_event);
        end else if (credit_event && (credits != CR_MAX)) begin
            credits_nx = credits + CRW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        o_s_ready    = 1'b0;
        o_busy       = (state != IDLE);
        o_frame_done = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_start) begin
                    state_nx = SEND;
                end
            end
            SEND: begin
                o_s_ready = 1'b1;
                if (line_end) begin
                    if (o_line_count == LINE_LAST) begin
                        state_nx = DONE;
                    end else if (credits_nx == '0) begin
                        state_nx = WAIT_CREDIT;
                    end
                end
            end
            WAIT_CREDIT: begin
                if (credits != '0) begin
                    state_nx = SEND;
                end
            end
            DONE: begin
                o_frame_done = 1'b1;
                state_nx     = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            col                <= '0;
            credits            <= '0;
            intr_d             <= 1'b0;
            o_line_count       <= '0;
            o_pixel_data       <= '0;
            o_pixel_data_valid <= 1'b0;
        end else begin
            intr_d             <= i_intr;
            credits            <= credits_nx;
            o_pixel_data_valid <= transfer;
            if (transfer) begin
                o_pixel_data <= i_s_data;
            end
            if (start_ok) begin
                col          <= '0;
                o_line_count <= '0;
            end else if (transfer) begin
                if (col == COL_LAST) begin
                    col          <= '0;
                    o_line_count <= o_line_count + LCW'(1);
                end else begin
                    col <= col + COLW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_pixel_stream_feeder.sv
// Directed bench for pixel_stream_feeder: a full-size instance for credit
// flow, a small 8x6 instance for complete frames and mid-frame reset.
module tb_pixel_stream_feeder;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    logic       b_start = 1'b0, b_valid = 1'b0, b_intr = 1'b0;
    logic [7:0] b_data = 8'd0;
    logic       b_ready, b_pv, b_busy, b_done;
    logic [7:0] b_pd;
    logic [9:0] b_lc;

    logic       s_start = 1'b0, s_valid = 1'b0, s_intr = 1'b0;
    logic [7:0] s_data = 8'd0;
    logic       s_ready, s_pv, s_busy, s_done;
    logic [7:0] s_pd;
    logic [2:0] s_lc;

    int   nchk = 0;
    int   nerr = 0;
    int   bsrc = 0;
    int   ssrc = 0;
    int   bexp = 0;
    logic bx_last = 1'b0;
    logic sx_last = 1'b0;

    always #5 clk = ~clk;

    pixel_stream_feeder dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(b_start),
        .i_s_data(b_data), .i_s_valid(b_valid), .o_s_ready(b_ready),
        .o_pixel_data(b_pd), .o_pixel_data_valid(b_pv), .i_intr(b_intr),
        .o_busy(b_busy), .o_line_count(b_lc), .o_frame_done(b_done)
    );

    pixel_stream_feeder #(.IMG_WIDTH(8), .IMG_HEIGHT(6), .PRELOAD_LINES(4)) dut_s (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(s_start),
        .i_s_data(s_data), .i_s_valid(s_valid), .o_s_ready(s_ready),
        .o_pixel_data(s_pd), .o_pixel_data_valid(s_pv), .i_intr(s_intr),
        .o_busy(s_busy), .o_line_count(s_lc), .o_frame_done(s_done)
    );

    // Called at a negedge with inputs set; returns at the next negedge
    // with both upstream source models advanced past any transfer.
    task automatic tick();
        logic bx, sx;
        bx = b_valid && b_ready;
        sx = s_valid && s_ready;
        @(posedge clk);
        @(negedge clk);
        if (bx) bsrc++;
        if (sx) ssrc++;
        b_data  = bsrc[7:0];
        s_data  = ssrc[7:0];
        bx_last = bx;
        sx_last = sx;
    endtask

    task automatic run_small(input int mid_start, input int stop_at,
                             output int n, output int dones,
                             output int done_at, output int lastv,
                             output int bad, output logic busy_after);
        n = 0; dones = 0; done_at = -1; lastv = -1; bad = -1;
        busy_after = 1'b1;
        s_valid = 1'b1;
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        for (int c = 0; c < 150; c++) begin
            s_intr  = s_pv && (n % 8 == 0) && (n > 0);
            s_start = (c == mid_start);
            tick();
            if (s_pv) begin
                if (s_pd !== n[7:0] && bad < 0) bad = n;
                n++;
                lastv = c;
            end
            if (s_done) begin
                dones++;
                done_at = c;
            end
            if (done_at >= 0 && c == done_at + 1) busy_after = s_busy;
            if (stop_at > 0 && n == stop_at) break;
        end
        s_intr  = 1'b0;
        s_start = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        nchk++;
        if ({b_ready, b_pv, b_busy, b_done, b_pd, b_lc} !== 22'd0) begin
            nerr++;
            $display("FAIL reset_big: got %h required 0",
                     {b_ready, b_pv, b_busy, b_done, b_pd, b_lc});
        end
        nchk++;
        if ({s_ready, s_pv, s_busy, s_done, s_pd, s_lc} !== 15'd0) begin
            nerr++;
            $display("FAIL reset_small: got %h required 0",
                     {s_ready, s_pv, s_busy, s_done, s_pd, s_lc});
        end
        @(negedge clk);
        rst_n   = 1'b1;
        b_valid = 1'b1;
        repeat (5) tick();
        nchk++;
        if ({b_ready, b_pv, b_busy} !== 3'b000) begin
            nerr++;
            $display("FAIL idle_no_start: ready/valid/busy %b required 000",
                     {b_ready, b_pv, b_busy});
        end
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        nchk++;
        if ({b_busy, b_ready} !== 2'b11) begin
            nerr++;
            $display("FAIL busy_after_start: busy/ready %b required 11",
                     {b_busy, b_ready});
        end
        repeat (10) tick();
        #2 rst_n = 1'b0;
        #1;
        nchk++;
        if ({b_ready, b_pv, b_busy, b_done, b_pd, b_lc} !== 22'd0) begin
            nerr++;
            $display("FAIL async_reset: got %h required 0",
                     {b_ready, b_pv, b_busy, b_done, b_pd, b_lc});
        end
        @(negedge clk);
        rst_n   = 1'b1;
        b_valid = 1'b0;
        bsrc = 0; b_data = 8'd0; bexp = 0; bx_last = 1'b0;
    endtask

    task automatic test_preload();
        int n = 0, first = -1, last = -1, bad = -1;
        b_valid = 1'b1;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int c = 0; c < 2048 + 40; c++) begin
            tick();
            if (b_pv) begin
                if (b_pd !== bexp[7:0] && bad < 0) bad = bexp;
                bexp++; n++;
                if (first < 0) first = c;
                last = c;
            end
        end
        nchk++;
        if (n !== 2048) begin
            nerr++; $display("FAIL preload_count: got %0d required 2048", n);
        end
        nchk++;
        if (bad !== -1) begin
            nerr++; $display("FAIL preload_order: bad index %0d required -1", bad);
        end
        nchk++;
        if (last - first !== 2047) begin
            nerr++;
            $display("FAIL preload_contig: span %0d required 2047", last - first);
        end
        nchk++;
        if (b_lc !== 10'd4 || b_ready !== 1'b0) begin
            nerr++;
            $display("FAIL preload_stall: lines %0d ready %b required 4 0",
                     b_lc, b_ready);
        end
    endtask

    task automatic test_refill();
        int n = 0, bad = -1;
        b_intr = 1'b1;
        tick();
        b_intr = 1'b0;
        nchk++;
        if (b_ready !== 1'b0) begin
            nerr++; $display("FAIL refill_m1: ready %b required 0", b_ready);
        end
        tick();
        nchk++;
        if (b_ready !== 1'b1) begin
            nerr++; $display("FAIL refill_m2: ready %b required 1", b_ready);
        end
        for (int c = 0; c < 560; c++) begin
            tick();
            if (b_pv) begin
                if (b_pd !== bexp[7:0] && bad < 0) bad = bexp;
                bexp++; n++;
            end
        end
        nchk++;
        if (n !== 512 || bad !== -1 || b_lc !== 10'd5 || b_ready !== 1'b0) begin
            nerr++;
            $display("FAIL refill_line: n %0d bad %0d lines %0d ready %b required 512 -1 5 0",
                     n, bad, b_lc, b_ready);
        end
        n = 0;
        for (int c = 0; c < 603; c++) begin
            b_intr = (c < 3);
            tick();
            if (b_pv) begin
                if (b_pd !== bexp[7:0] && bad < 0) bad = bexp;
                bexp++; n++;
            end
        end
        b_intr = 1'b0;
        nchk++;
        if (n !== 512 || bad !== -1 || b_lc !== 10'd6) begin
            nerr++;
            $display("FAIL wide_intr: n %0d bad %0d lines %0d required 512 -1 6",
                     n, bad, b_lc);
        end
    endtask

    task automatic test_coincident();
        int n = 0, t = 0, first = -1, last = -1, bad = -1;
        b_intr = 1'b1;
        tick();
        for (int c = 0; c < 1100; c++) begin
            b_intr = b_ready && b_valid && (t == 511);
            tick();
            if (bx_last) t++;
            if (b_pv) begin
                if (b_pd !== bexp[7:0] && bad < 0) bad = bexp;
                bexp++; n++;
                if (first < 0) first = c;
                last = c;
            end
        end
        b_intr = 1'b0;
        nchk++;
        if (n !== 1024 || bad !== -1) begin
            nerr++;
            $display("FAIL coinc_count: n %0d bad %0d required 1024 -1", n, bad);
        end
        nchk++;
        if (last - first !== 1023) begin
            nerr++;
            $display("FAIL coinc_no_gap: span %0d required 1023", last - first);
        end
        nchk++;
        if (b_lc !== 10'd8 || b_ready !== 1'b0) begin
            nerr++;
            $display("FAIL coinc_stall: lines %0d ready %b required 8 0",
                     b_lc, b_ready);
        end
    endtask

    task automatic test_bubbly();
        int n = 0, bad = -1, vbad = 0, tail = 0;
        b_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bsrc = 0; b_data = 8'd0; bexp = 0;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int c = 0; c < 8000; c++) begin
            b_valid = 1'($urandom_range(0, 1));
            tick();
            if (b_pv !== bx_last) vbad++;
            if (b_pv) begin
                if (b_pd !== bexp[7:0] && bad < 0) bad = bexp;
                bexp++; n++;
            end
            if (n >= 2048) begin
                tail++;
                if (tail > 20) break;
            end
        end
        b_valid = 1'b0;
        nchk++;
        if (n !== 2048 || bad !== -1) begin
            nerr++;
            $display("FAIL bubbly_count: n %0d bad %0d required 2048 -1", n, bad);
        end
        nchk++;
        if (vbad !== 0) begin
            nerr++;
            $display("FAIL bubbly_valid: mismatched cycles %0d required 0", vbad);
        end
        nchk++;
        if (b_lc !== 10'd4) begin
            nerr++; $display("FAIL bubbly_lines: got %0d required 4", b_lc);
        end
    endtask

    task automatic test_full_frame();
        int   n, dones, done_at, lastv, bad;
        logic busy_after;
        ssrc = 0; s_data = 8'd0;
        run_small(20, 0, n, dones, done_at, lastv, bad, busy_after);
        nchk++;
        if (n !== 48 || bad !== -1) begin
            nerr++;
            $display("FAIL frame_pixels: n %0d bad %0d required 48 -1", n, bad);
        end
        nchk++;
        if (dones !== 1 || done_at !== lastv) begin
            nerr++;
            $display("FAIL frame_done: pulses %0d at %0d last valid %0d required 1 at last",
                     dones, done_at, lastv);
        end
        nchk++;
        if (busy_after !== 1'b0 || s_busy !== 1'b0 || s_lc !== 3'd6) begin
            nerr++;
            $display("FAIL frame_idle: busy_after %b busy %b lines %0d required 0 0 6",
                     busy_after, s_busy, s_lc);
        end
        ssrc = 0; s_data = 8'd0;
        run_small(-1, 20, n, dones, done_at, lastv, bad, busy_after);
        #2 rst_n = 1'b0;
        #1;
        nchk++;
        if ({s_busy, s_ready, s_pv, s_lc} !== 6'd0) begin
            nerr++;
            $display("FAIL midline_reset: busy/ready/valid/lines %b required 0",
                     {s_busy, s_ready, s_pv, s_lc});
        end
        @(negedge clk);
        rst_n = 1'b1;
        ssrc = 0; s_data = 8'd0;
        run_small(-1, 0, n, dones, done_at, lastv, bad, busy_after);
        nchk++;
        if (n !== 48 || bad !== -1 || dones !== 1 || s_lc !== 3'd6) begin
            nerr++;
            $display("FAIL rerun_frame: n %0d bad %0d done %0d lines %0d required 48 -1 1 6",
                     n, bad, dones, s_lc);
        end
    endtask

    initial begin
        test_reset();
        test_preload();
        test_refill();
        test_coincident();
        test_bubbly();
        test_full_frame();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nerr);
        $finish;
    end

endmodule

// File: doc/pixel_stream_feeder.md
# pixel_stream_feeder

Sends a raster image from an upstream ready/valid pixel source into the 4-line-buffer window controller, one 8-bit pixel per cycle. Flow control is line-credit based. Starting a frame grants PRELOAD_LINES credits. Each end-of-line interrupt from the window controller grants one more, so the controller's line buffers never take more lines than they can hold. The block sits between the image source (DMA/testbench stream) and the window controller's pixel input.

## Interface
- IMG_WIDTH, 512, pixels per line
- IMG_HEIGHT, 512, lines per frame
- PRELOAD_LINES, 4, credits granted at frame start; also the credit ceiling
- i_clk  in  1  clock; all logic on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  frame start pulse; sampled only in IDLE
- i_s_data  in  8  upstream pixel
- i_s_valid  in  1  upstream pixel valid
- o_s_ready  out  1  upstream ready; transfer = i_s_valid & o_s_ready
- o_pixel_data  out  8  pixel to window controller
- o_pixel_data_valid  out  1  pixel valid to window controller
- i_intr  in  1  line-consumed interrupt from window controller
- o_busy  out  1  high whenever state != IDLE
- o_line_count  out  $clog2(IMG_HEIGHT+1)  lines fully sent in current frame
- o_frame_done  out  1  one-cycle pulse after last pixel of frame accepted

## Operation
- States: IDLE, SEND, WAIT_CREDIT, DONE.
- IDLE: o_s_ready=0. On i_start=1: col<=0, o_line_count<=0, credits<=PRELOAD_LINES, go to SEND.
- SEND: o_s_ready=1 combinationally. On each transfer, o_pixel_data<=i_s_data, and col increments.
- Last pixel of a line is a transfer with col==IMG_WIDTH-1. On it:
  - col<=0 and o_line_count increments.
  - credits<=credits-1+credit_event.
  - If o_line_count was IMG_HEIGHT-1, go to DONE.
  - Else if the new credits==0, go to WAIT_CREDIT.
  - Else stay in SEND.
- WAIT_CREDIT: o_s_ready=0. When credits>0, go to SEND.
- DONE: o_frame_done=1 for this single cycle, then go to IDLE. o_line_count holds IMG_HEIGHT until the next i_start.
- credit_event is a rising edge of i_intr: i_intr=1 while the registered i_intr_d=0. i_intr_d resets to 0.
  - One credit per edge, in any state except IDLE and DONE. Edges in IDLE or DONE are discarded.
  - credits saturates at PRELOAD_LINES. An extra edge at the ceiling is dropped.
- Credit register is 3 bits for the default PRELOAD_LINES (generally $clog2(PRELOAD_LINES+1)).
- Decrement and credit_event in the same cycle: net change 0. No underflow, no lost credit, no stall.
- i_start outside IDLE is ignored.
- When i_s_valid=0 in SEND, no transfer occurs. Counters hold and o_pixel_data_valid is 0 next cycle.
- Pixel order is preserved exactly. There is no internal storage beyond the single output register.

## Timing
- Reset (async assert, sync-safe release): state=IDLE, col=0, credits=0, i_intr_d=0.
- Output reset values: o_pixel_data=0, o_pixel_data_valid=0, o_s_ready=0, o_busy=0, o_line_count=0, o_frame_done=0.
- Reset mid-frame takes effect immediately: outputs clear without waiting for a clock, and the in-progress frame is abandoned.
- Latency: a transfer in cycle N gives o_pixel_data_valid=1 with that pixel in cycle N+1. o_pixel_data_valid is registered and equals the transfer of the previous cycle.
- Steady source: with credits available, one pixel per cycle, back-to-back across line boundaries with no bubble.
- Stall entry: o_s_ready falls in the cycle after the last pixel of the zero-credit line.
- Stall exit: a credit_event in cycle M gives credits=1 at M+1, SEND at M+2, and o_s_ready=1 at M+2.
- o_frame_done fires 1 cycle after the final transfer, coincident with the final o_pixel_data_valid. o_busy falls the cycle after that.
- o_busy goes high the cycle after i_start is accepted.

## Test plan
- Reset: assert i_rst_n=0 asynchronously between clock edges -> all outputs 0 immediately. Drive i_s_valid=1 with no i_start -> o_s_ready stays 0 and no valid output.
- Preload: i_start, source always valid with data=index mod 256, i_intr=0 -> exactly 2048 contiguous valid pixels in order. o_line_count=4, then o_s_ready=0 indefinitely.
- Credit refill: after the preload stall, one 1-cycle i_intr pulse -> o_s_ready high 2 cycles later, exactly 512 more pixels, o_line_count=5, stall again. A 3-cycle-wide i_intr pulse -> still only one credit.
- Coincident credit: i_intr edge in the same cycle as the last pixel of line 4 -> credits stays 1 with no o_s_ready gap. With no further intr -> exactly line 5 is sent, then stall.
- Bubbly source: i_s_valid random ~50% through the preload -> 2048 valid outputs, order intact, and o_pixel_data_valid never set in a cycle following a non-transfer.
- Full frame: IMG_WIDTH=8, IMG_HEIGHT=6, i_intr pulse after every 8 outputs -> 48 pixels, o_line_count=6, single o_frame_done pulse, return to IDLE. An i_start mid-frame is ignored. A rerun with i_rst_n asserted mid-line 3 -> clean IDLE, and the next i_start begins again at col 0, line 0.
